// File: rtl/rvfi_retire_serializer.sv
// ----------------------------------------------------------------------------
// rvfi_retire_serializer
//
// Takes up to NRET retirements per cycle from a multi-channel RVFI bus and
// buffers them in a FIFO. It replays them one per cycle, in program order, to a
// single-channel checker. Two sticky flags report dropped retirements
// (overflow) and gaps or reordering in rvfi_order (order_err).
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous reset, active high
//   enable       in   capture enable (the FIFO keeps draining while low)
//   in_valid     in   [NRET]      per-channel retire strobe
//   in_order     in   [NRET*8]    per-channel rvfi_order
//   in_payload   in   [NRET*PW]   per-channel opaque payload
//   out_valid    out  FIFO head is valid
//   out_ready    in   downstream accepts the head
//   out_channel  out  [CW]        source channel of the head
//   out_order    out  [8]         rvfi_order of the head
//   out_payload  out  [PW]        payload of the head
//   level        out  [LW]        current occupancy
//   overflow     out  sticky: a whole cycle of retirements was dropped
//   order_err    out  sticky: rvfi_order sequence violation
// ----------------------------------------------------------------------------
module rvfi_retire_serializer #(
    parameter  int NRET        = 2,
    parameter  int PW          = 200,
    parameter  int DEPTH       = 8,   // power of two, >= NRET
    parameter  int CHECK_ORDER = 1,
    localparam int CW          = (NRET > 1) ? $clog2(NRET) : 1,
    localparam int LW          = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NRET-1:0]      in_valid,
    input  logic [NRET*8-1:0]    in_order,
    input  logic [NRET*PW-1:0]   in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_channel,
    output logic [7:0]           out_order,
    output logic [PW-1:0]        out_payload,
    output logic [LW-1:0]        level,
    output logic                 overflow,
    output logic                 order_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int KW = $clog2(NRET + 1);
    localparam int FW = LW + 1;

    // Entry storage, split per field.
    logic [CW-1:0]  r_chan [DEPTH];
    logic [7:0]     r_ord  [DEPTH];
    logic [PW-1:0]  r_pay  [DEPTH];

    logic [AW-1:0]  r_rptr;
    logic [AW-1:0]  r_wptr;
    logic [LW-1:0]  r_count;
    logic [7:0]     r_expected;
    logic           r_overflow;
    logic           r_order_err;

    logic [NRET-1:0] w_cap;
    logic [KW-1:0]   w_k;
    logic [AW-1:0]   w_slot [NRET];
    logic            w_pop;
    logic [FW-1:0]   w_free;
    logic            w_accept;
    logic            w_ord_bad;
    logic [7:0]      w_next_exp;

    // Compaction and order check share one walk over the channels in
    // ascending index: w_k is the running count of captured channels, which
    // is both the slot offset and the expected-order offset of the next one.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so the running count
        // updates within the loop; every output gets a default first so no
        // latch is inferred.
        w_cap      = enable ? in_valid : '0;
        w_pop      = (r_count != '0) && out_ready;
        w_k        = '0;
        w_ord_bad  = 1'b0;
        w_next_exp = r_expected;
        for (int i = 0; i < NRET; i++) begin
            w_slot[i] = r_wptr + AW'(w_k);
            if (w_cap[i]) begin
                if (in_order[i*8 +: 8] != (r_expected + 8'(w_k)))
                    w_ord_bad = 1'b1;
                // Resync to the last captured order so one fault flags once.
                w_next_exp = in_order[i*8 +: 8] + 8'd1;
                w_k        = w_k + KW'(1);
            end
        end
        // A slot vacated by this cycle's pop can be refilled in the same cycle.
        w_free   = FW'(DEPTH) - FW'(r_count) + FW'(w_pop);
        // All-or-nothing: a cycle that does not fit entirely is dropped.
        w_accept = (FW'(w_k) <= w_free);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rptr      <= '0;
            r_wptr      <= '0;
            r_count     <= '0;
            r_expected  <= '0;
            r_overflow  <= 1'b0;
            r_order_err <= 1'b0;
            // NOTE: storage is cleared on reset so the head outputs read zero
            // afterwards; this keeps the array in flops rather than a RAM.
            for (int e = 0; e < DEPTH; e++) begin
                r_chan[e] <= '0;
                r_ord[e]  <= '0;
                r_pay[e]  <= '0;
            end
        end else begin
            if (w_accept) begin
                for (int i = 0; i < NRET; i++) begin
                    if (w_cap[i]) begin
                        r_chan[w_slot[i]] <= CW'(i);
                        r_ord[w_slot[i]]  <= in_order[i*8 +: 8];
                        r_pay[w_slot[i]]  <= in_payload[i*PW +: PW];
                    end
                end
                r_wptr <= r_wptr + AW'(w_k);
            end else begin
                r_overflow <= 1'b1;
            end

            if (w_pop)
                r_rptr <= r_rptr + AW'(1);

            r_count <= r_count + (w_accept ? LW'(w_k) : '0) - LW'(w_pop);

            // Expected order follows the traffic even on a dropped cycle so
            // post-overflow retirements are not also reported as a gap.
            r_expected <= w_next_exp;

            if ((CHECK_ORDER != 0) && w_accept && w_ord_bad)
                r_order_err <= 1'b1;
        end
    end

    assign out_valid   = (r_count != '0);
    assign out_channel = r_chan[r_rptr];
    assign out_order   = r_ord[r_rptr];
    assign out_payload = r_pay[r_rptr];
    assign level       = r_count;
    assign overflow    = r_overflow;
    assign order_err   = r_order_err;

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// ----------------------------------------------------------------------------
// tb_rvfi_retire_serializer
//
// Directed scenarios followed by a randomized run. A queue-based reference
// model applies the capture, drop, pop and order-check rules each clock edge;
// every output is compared against it one time unit after the edge.
// ----------------------------------------------------------------------------
module tb_rvfi_retire_serializer;

    localparam int NRET  = 2;
    localparam int PW    = 200;
    localparam int DEPTH = 8;
    localparam int CW    = 1;
    localparam int LW    = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [NRET-1:0]    in_valid;
    logic [NRET*8-1:0]  in_order;
    logic [NRET*PW-1:0] in_payload;
    logic               out_valid;
    logic               out_ready;
    logic [CW-1:0]      out_channel;
    logic [7:0]         out_order;
    logic [PW-1:0]      out_payload;
    logic [LW-1:0]      level;
    logic               overflow;
    logic               order_err;

    always #5 clk = ~clk;

    rvfi_retire_serializer #(
        .NRET(NRET), .PW(PW), .DEPTH(DEPTH), .CHECK_ORDER(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_order(in_order), .in_payload(in_payload),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_channel(out_channel), .out_order(out_order),
        .out_payload(out_payload), .level(level),
        .overflow(overflow), .order_err(order_err)
    );

    typedef struct {
        logic [CW-1:0] ch;
        logic [7:0]    ord;
        logic [PW-1:0] pay;
    } ent_t;

    ent_t       mq[$];
    bit         m_over;
    bit         m_err;
    logic [7:0] m_exp;
    logic [7:0] drv_ord;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_pay();
        logic [223:0] t;
        for (int w = 0; w < 7; w++) t[w*32 +: 32] = $urandom();
        return t[PW-1:0];
    endfunction

    // Reference model: applies one clock edge using the inputs held now.
    task automatic model_edge();
        ent_t cap[$];
        bit   pop;
        int   free;
        if (reset) begin
            mq.delete();
            m_over = 0;
            m_err  = 0;
            m_exp  = 8'd0;
            return;
        end
        for (int i = 0; i < NRET; i++) begin
            if (enable && in_valid[i]) begin
                ent_t e;
                e.ch  = CW'(i);
                e.ord = in_order[i*8 +: 8];
                e.pay = in_payload[i*PW +: PW];
                cap.push_back(e);
            end
        end
        pop  = (mq.size() != 0) && out_ready;
        free = DEPTH - mq.size() + (pop ? 1 : 0);
        if (pop) void'(mq.pop_front());
        if (cap.size() <= free) begin
            foreach (cap[j]) begin
                if (cap[j].ord != 8'(m_exp + 8'(j))) m_err = 1;
                mq.push_back(cap[j]);
            end
        end else begin
            m_over = 1;
        end
        if (cap.size() != 0) m_exp = cap[cap.size()-1].ord + 8'd1;
    endtask

    task automatic compare_all();
        check("out_valid", out_valid, mq.size() != 0);
        check("level", level, mq.size());
        check("overflow", overflow, m_over);
        check("order_err", order_err, m_err);
        if (mq.size() != 0) begin
            check("out_channel", out_channel, mq[0].ch);
            check("out_order", out_order, mq[0].ord);
            check("out_payload", out_payload, mq[0].pay);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_in(input logic e, input logic [1:0] v, input logic [7:0] o0,
                          input logic [7:0] o1, input logic r);
        enable     = e;
        in_valid   = v;
        in_order   = {o1, o0};
        in_payload = {rand_pay(), rand_pay()};
        out_ready  = r;
    endtask

    // Drives in-sequence orders on the valid channels; 'bad' perturbs ch0.
    task automatic gen(input logic e, input logic [1:0] v, input logic r,
                       input bit bad);
        logic [7:0] a = 8'($urandom());
        logic [7:0] b = 8'($urandom());
        if (e && v[0]) begin a = drv_ord; drv_ord++; end
        if (e && v[1]) begin b = drv_ord; drv_ord++; end
        if (bad) a = a + 8'($urandom_range(1, 5));
        set_in(e, v, a, b, r);
        cycle();
    endtask

    task automatic idle(input logic r);
        set_in(1'b1, 2'b00, 8'd0, 8'd0, r);
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(1'b1, 2'b11, 8'd0, 8'd1, 1'b1);
        cycle();
        reset   = 1'b0;
        drv_ord = 8'd0;
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 2'b00, 8'd0, 8'd0, 1'b0);
        do_reset();
        check("rst_out_order", out_order, 8'd0);
        check("rst_out_channel", out_channel, 1'b0);
        check("rst_out_payload", out_payload, '0);

        // Single channel, orders 0,1,2 back to back, then 3,4.
        gen(1'b1, 2'b01, 1'b1, 0);
        check("single_first_valid", out_valid, 1'b1);
        check("single_first_order", out_order, 8'd0);
        for (int i = 0; i < 4; i++) gen(1'b1, 2'b01, 1'b1, 0);
        idle(1'b1);
        idle(1'b1);

        // Dual retire 5/ch0, 6/ch1 into an empty FIFO.
        gen(1'b1, 2'b11, 1'b1, 0);
        check("dual_level_peak", level, 4'd2);
        idle(1'b1);
        check("dual_second_ch", out_channel, 1'b1);
        idle(1'b1);

        // Backpressure: fill to 8, then one dropped dual capture, then drain.
        for (int i = 0; i < 4; i++) gen(1'b1, 2'b11, 1'b0, 0);
        check("bp_full_level", level, 4'd8);
        check("bp_full_no_ovf", overflow, 1'b0);
        gen(1'b1, 2'b11, 1'b0, 0);
        check("bp_drop_ovf", overflow, 1'b1);
        check("bp_drop_level", level, 4'd8);
        for (int i = 0; i < 8; i++) idle(1'b1);
        check("bp_drained", level, 4'd0);

        // Full plus simultaneous pop.
        do_reset();
        for (int i = 0; i < 4; i++) gen(1'b1, 2'b11, 1'b0, 0);
        gen(1'b1, 2'b01, 1'b1, 0);
        check("fullpop_k1_level", level, 4'd8);
        check("fullpop_k1_ovf", overflow, 1'b0);
        gen(1'b1, 2'b11, 1'b1, 0);
        check("fullpop_k2_ovf", overflow, 1'b1);
        check("fullpop_k2_level", level, 4'd7);

        // Order gap 0,1,3,4 on ch0.
        do_reset();
        set_in(1'b1, 2'b01, 8'd0, 8'd0, 1'b1); cycle();
        set_in(1'b1, 2'b01, 8'd1, 8'd0, 1'b1); cycle();
        check("gap_before", order_err, 1'b0);
        set_in(1'b1, 2'b01, 8'd3, 8'd0, 1'b1); cycle();
        check("gap_flag", order_err, 1'b1);
        set_in(1'b1, 2'b01, 8'd4, 8'd0, 1'b1); cycle();
        idle(1'b1);

        // Swapped dual retire {ch0=8, ch1=7} after 0..6.
        do_reset();
        for (int i = 0; i < 7; i++) gen(1'b1, 2'b01, 1'b1, 0);
        check("swap_before", order_err, 1'b0);
        set_in(1'b1, 2'b11, 8'd8, 8'd7, 1'b1); cycle();
        check("swap_flag", order_err, 1'b1);

        // Mid-stream reset with 3 entries buffered and both stickies set.
        for (int g = 0; g < 20 && mq.size() < DEPTH; g++) gen(1'b1, 2'b01, 1'b0, 0);
        gen(1'b1, 2'b11, 1'b0, 0);
        for (int g = 0; g < 20 && mq.size() > 3; g++) idle(1'b1);
        check("mid_level3", level, 4'd3);
        check("mid_ovf_set", overflow, 1'b1);
        check("mid_err_set", order_err, 1'b1);
        do_reset();
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_level", level, 4'd0);
        check("mid_rst_ovf", overflow, 1'b0);
        check("mid_rst_err", order_err, 1'b0);
        gen(1'b1, 2'b01, 1'b1, 0);
        check("mid_post_order", out_order, 8'd0);
        check("mid_post_err", order_err, 1'b0);

        // Randomized run.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(63) == 0) begin
                do_reset();
            end else begin
                gen($urandom_range(9) != 0, 2'($urandom_range(3)),
                    $urandom_range(9) < 6, $urandom_range(31) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
